// File: rtl/axi4_slave_mem.sv
// -----------------------------------------------------------------------------
// axi4_slave_mem
//
// Purpose:
//   Synthesizable AXI4 slave memory model. Word-addressed RAM with burst
//   support and independent read/write FSMs. One outstanding transaction per
//   direction; both directions may be active at the same time.
//
// Optional feature:
//   AXI4_MEM_WRAP_EN  - when defined, WRAP bursts are executed per AXI4
//                       (len must be 1/3/7/15). When undefined, WRAP and
//                       reserved bursts are drained at full beat count with no
//                       RAM access and an SLVERR response.
//
// Ports:
//   clk, rst_n                      - clock, synchronous active-low reset
//   aw*  (awid .. awready)          - write address channel
//   w*   (wdata .. wready)          - write data channel
//   b*   (bid .. bready)            - write response channel
//   ar*  (arid .. arready)          - read address channel
//   r*   (rid .. rready)            - read data channel
// -----------------------------------------------------------------------------
module axi4_slave_mem #(
    parameter int unsigned ID_W      = 4,
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned MEM_DEPTH = 4096,
    parameter int unsigned RD_LAT    = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    // write address
    input  logic [ID_W-1:0]     awid,
    input  logic [ADDR_W-1:0]   awaddr,
    input  logic [7:0]          awlen,
    input  logic [2:0]          awsize,
    input  logic [1:0]          awburst,
    input  logic                awvalid,
    output logic                awready,
    // write data
    input  logic [DATA_W-1:0]   wdata,
    input  logic [DATA_W/8-1:0] wstrb,
    input  logic                wlast,
    input  logic                wvalid,
    output logic                wready,
    // write response
    output logic [ID_W-1:0]     bid,
    output logic [1:0]          bresp,
    output logic                bvalid,
    input  logic                bready,
    // read address
    input  logic [ID_W-1:0]     arid,
    input  logic [ADDR_W-1:0]   araddr,
    input  logic [7:0]          arlen,
    input  logic [2:0]          arsize,
    input  logic [1:0]          arburst,
    input  logic                arvalid,
    output logic                arready,
    // read data
    output logic [ID_W-1:0]     rid,
    output logic [DATA_W-1:0]   rdata,
    output logic [1:0]          rresp,
    output logic                rlast,
    output logic                rvalid,
    input  logic                rready
);

    localparam int unsigned IDX_W  = $clog2(MEM_DEPTH);
    localparam int          NB     = int'(DATA_W / 8);
    localparam int unsigned LAT_M1 = (RD_LAT > 0) ? RD_LAT - 1 : 0;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;
    localparam logic [1:0] BURST_RSVD  = 2'b11;

    typedef enum logic [1:0] {WIdle, WData, WResp} wstate_e;
    typedef enum logic [1:0] {RIdle, RWait, RData} rstate_e;

    logic [DATA_W-1:0] mem [MEM_DEPTH];

    // ---------------------------------------------------------------------
    // Burst legality (decoded from the live address-channel inputs)
    // ---------------------------------------------------------------------
`ifdef AXI4_MEM_WRAP_EN
    function automatic logic wrap_len_ok(input logic [7:0] len);
        return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
    endfunction
`endif

    logic aw_bad, ar_bad;

    always_comb begin
        aw_bad = (awsize > 3'd2);
        ar_bad = (arsize > 3'd2);
`ifdef AXI4_MEM_WRAP_EN
        if (awburst == BURST_RSVD) aw_bad = 1'b1;
        if (arburst == BURST_RSVD) ar_bad = 1'b1;
        if ((awburst == BURST_WRAP) && !wrap_len_ok(awlen)) aw_bad = 1'b1;
        if ((arburst == BURST_WRAP) && !wrap_len_ok(arlen)) ar_bad = 1'b1;
`else
        // Without wrap support these bursts are accepted but never touch RAM.
        if ((awburst == BURST_WRAP) || (awburst == BURST_RSVD)) aw_bad = 1'b1;
        if ((arburst == BURST_WRAP) || (arburst == BURST_RSVD)) ar_bad = 1'b1;
`endif
    end

    // ---------------------------------------------------------------------
    // Write channel state
    // ---------------------------------------------------------------------
    wstate_e           wstate_q;
    logic              awready_q, wready_q, bvalid_q;
    logic [ID_W-1:0]   bid_q, wid_q;
    logic [1:0]        bresp_q;
    logic [ADDR_W-1:0] waddr_q, w_addr_nxt, w_incr;
    logic [7:0]        wlen_q, wbeat_q;
    logic [2:0]        wsize_q;
    logic [1:0]        wburst_q;
    logic              wbad_q, wlast_err_q;
    logic              w_hs, w_last_mis, mem_we;
    logic [IDX_W-1:0]  w_idx;
`ifdef AXI4_MEM_WRAP_EN
    logic [ADDR_W-1:0] w_mask;
`endif

    always_comb begin
        w_incr     = ADDR_W'(1) << wsize_q;
        w_addr_nxt = waddr_q;
        if (wburst_q == BURST_INCR) w_addr_nxt = waddr_q + w_incr;
`ifdef AXI4_MEM_WRAP_EN
        w_mask = ((ADDR_W'(wlen_q) + ADDR_W'(1)) << wsize_q) - ADDR_W'(1);
        if (wburst_q == BURST_WRAP) begin
            w_addr_nxt = (waddr_q & ~w_mask) | ((waddr_q + w_incr) & w_mask);
        end
`endif
    end

    assign w_hs       = wvalid && wready_q;
    assign w_last_mis = (wlast != (wbeat_q == wlen_q));
    assign w_idx      = waddr_q[IDX_W+1:2];
    // Writes are suppressed during reset so a mid-burst reset commits nothing more.
    assign mem_we     = w_hs && !wbad_q && rst_n;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wstate_q    <= WIdle;
            awready_q   <= 1'b0;
            wready_q    <= 1'b0;
            bvalid_q    <= 1'b0;
            bid_q       <= '0;
            bresp_q     <= RESP_OKAY;
            wid_q       <= '0;
            waddr_q     <= '0;
            wlen_q      <= '0;
            wsize_q     <= '0;
            wburst_q    <= '0;
            wbeat_q     <= '0;
            wbad_q      <= 1'b0;
            wlast_err_q <= 1'b0;
        end else begin
            case (wstate_q)
                WIdle: begin
                    awready_q <= 1'b1;
                    if (awvalid && awready_q) begin
                        wid_q       <= awid;
                        waddr_q     <= awaddr;
                        wlen_q      <= awlen;
                        wsize_q     <= awsize;
                        wburst_q    <= awburst;
                        wbad_q      <= aw_bad;
                        wbeat_q     <= '0;
                        wlast_err_q <= 1'b0;
                        awready_q   <= 1'b0;
                        wready_q    <= 1'b1;
                        wstate_q    <= WData;
                    end
                end
                WData: begin
                    if (w_hs) begin
                        waddr_q <= w_addr_nxt;
                        wbeat_q <= wbeat_q + 8'd1;
                        if (w_last_mis) wlast_err_q <= 1'b1;
                        // Beat count, not wlast, ends the burst.
                        if (wbeat_q == wlen_q) begin
                            wready_q <= 1'b0;
                            bvalid_q <= 1'b1;
                            bid_q    <= wid_q;
                            bresp_q  <= (wbad_q || wlast_err_q || w_last_mis) ?
                                        RESP_SLVERR : RESP_OKAY;
                            wstate_q <= WResp;
                        end
                    end
                end
                WResp: begin
                    if (bready) begin
                        bvalid_q  <= 1'b0;
                        awready_q <= 1'b1;
                        wstate_q  <= WIdle;
                    end
                end
                default: wstate_q <= WIdle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < NB; b++) begin
                if (wstrb[b]) mem[w_idx][b*8 +: 8] <= wdata[b*8 +: 8];
            end
        end
    end

    // ---------------------------------------------------------------------
    // Read channel state
    // ---------------------------------------------------------------------
    rstate_e           rstate_q;
    logic              arready_q, rvalid_q, rlast_q;
    logic [ID_W-1:0]   rid_q;
    logic [1:0]        rresp_q;
    logic [DATA_W-1:0] rdata_q, rd_word;
    logic [ADDR_W-1:0] raddr_q, r_addr_nxt, r_incr;
    logic [7:0]        rlen_q, rbeat_q;
    logic [2:0]        rsize_q;
    logic [1:0]        rburst_q;
    logic              rbad_q;
    logic [3:0]        rlat_q;
    logic [IDX_W-1:0]  rd_idx;
`ifdef AXI4_MEM_WRAP_EN
    logic [ADDR_W-1:0] r_mask;
`endif

    always_comb begin
        r_incr     = ADDR_W'(1) << rsize_q;
        r_addr_nxt = raddr_q;
        if (rburst_q == BURST_INCR) r_addr_nxt = raddr_q + r_incr;
`ifdef AXI4_MEM_WRAP_EN
        r_mask = ((ADDR_W'(rlen_q) + ADDR_W'(1)) << rsize_q) - ADDR_W'(1);
        if (rburst_q == BURST_WRAP) begin
            r_addr_nxt = (raddr_q & ~r_mask) | ((raddr_q + r_incr) & r_mask);
        end
`endif
    end

    // Address of the beat being loaded into rdata_q at the coming edge.
    always_comb begin
        case (rstate_q)
            RIdle:   rd_idx = araddr[IDX_W+1:2];
            RWait:   rd_idx = raddr_q[IDX_W+1:2];
            default: rd_idx = r_addr_nxt[IDX_W+1:2];
        endcase
    end

    // Registered read: a same-edge write is not visible, so old data is returned.
    assign rd_word = mem[rd_idx];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rstate_q  <= RIdle;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rlast_q   <= 1'b0;
            rid_q     <= '0;
            rresp_q   <= RESP_OKAY;
            rdata_q   <= '0;
            raddr_q   <= '0;
            rlen_q    <= '0;
            rsize_q   <= '0;
            rburst_q  <= '0;
            rbeat_q   <= '0;
            rbad_q    <= 1'b0;
            rlat_q    <= '0;
        end else begin
            case (rstate_q)
                RIdle: begin
                    arready_q <= 1'b1;
                    if (arvalid && arready_q) begin
                        rid_q     <= arid;
                        raddr_q   <= araddr;
                        rlen_q    <= arlen;
                        rsize_q   <= arsize;
                        rburst_q  <= arburst;
                        rbad_q    <= ar_bad;
                        rbeat_q   <= '0;
                        arready_q <= 1'b0;
                        if (RD_LAT == 0) begin
                            rvalid_q <= 1'b1;
                            rdata_q  <= ar_bad ? '0 : rd_word;
                            rresp_q  <= ar_bad ? RESP_SLVERR : RESP_OKAY;
                            rlast_q  <= (arlen == 8'd0);
                            rstate_q <= RData;
                        end else begin
                            rlat_q   <= 4'(LAT_M1);
                            rstate_q <= RWait;
                        end
                    end
                end
                RWait: begin
                    if (rlat_q == 4'd0) begin
                        rvalid_q <= 1'b1;
                        rdata_q  <= rbad_q ? '0 : rd_word;
                        rresp_q  <= rbad_q ? RESP_SLVERR : RESP_OKAY;
                        rlast_q  <= (rlen_q == 8'd0);
                        rstate_q <= RData;
                    end else begin
                        rlat_q <= rlat_q - 4'd1;
                    end
                end
                RData: begin
                    // rdata/rlast/rresp only change on a handshake, so they hold on stalls.
                    if (rready) begin
                        if (rlast_q) begin
                            rvalid_q  <= 1'b0;
                            rlast_q   <= 1'b0;
                            arready_q <= 1'b1;
                            rstate_q  <= RIdle;
                        end else begin
                            raddr_q <= r_addr_nxt;
                            rbeat_q <= rbeat_q + 8'd1;
                            rdata_q <= rbad_q ? '0 : rd_word;
                            rlast_q <= ((rbeat_q + 8'd1) == rlen_q);
                        end
                    end
                end
                default: rstate_q <= RIdle;
            endcase
        end
    end

    assign awready = awready_q;
    assign wready  = wready_q;
    assign bvalid  = bvalid_q;
    assign bid     = bid_q;
    assign bresp   = bresp_q;
    assign arready = arready_q;
    assign rvalid  = rvalid_q;
    assign rlast   = rlast_q;
    assign rid     = rid_q;
    assign rresp   = rresp_q;
    assign rdata   = rdata_q;

endmodule
